// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Microcode sequencer for the 8-bit bus CPU. Walks a T-state counter and
//   decodes (step, opcode, flags) into the 16-bit control word consumed by the
//   A/B registers, ALU, RAM, PC, IR and output register.
//
//   Optional build macro: CONTROL_SEQUENCER_EARLY_END_EN
//     defined   - from T2 onward, an all-zero word ends the instruction early
//     undefined - every instruction runs all STEPS T-states
//
// Ports
//   clk          in   system clock, rising edge
//   clear_n      in   synchronous active-low reset
//   step_en      in   advance enable (manual single-step)
//   opcode[3:0]  in   IR[7:4]
//   carry_flag   in   ALU carry flag (sampled live)
//   zero_flag    in   ALU zero flag (sampled live)
//   control_word out  16 control bits (HLT..FI at bits 15..0)
//   step[2:0]    out  current T-state
//   halted       out  CPU halted
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int STEPS = 5
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] control_word,
    output logic [2:0]  step,
    output logic        halted
);

    // Control bits, shared CW bit indices
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    logic [15:0] word;   // decoded microcode word, before halt/reset gating

    always_comb begin
        word = 16'h0000;
        case (step)
            3'd0: word = MI | CO;
            3'd1: word = RO | II | CE;
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: word = MI | IO;
                    OP_LDI: word = IO | AI;
                    OP_JMP: word = IO | J;
                    OP_JC:  word = carry_flag ? (IO | J) : 16'h0000;
                    OP_JZ:  word = zero_flag  ? (IO | J) : 16'h0000;
                    OP_OUT: word = AO | OI;
                    OP_HLT: word = HLT;
                    default: word = 16'h0000;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA: word = RO | AI;
                    OP_ADD, OP_SUB: word = RO | BI;
                    OP_STA: word = AO | RI;
                    default: word = 16'h0000;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD: word = EO | AI | FI;
                    OP_SUB: word = EO | AI | SU | FI;
                    default: word = 16'h0000;
                endcase
            end
            default: word = 16'h0000;
        endcase
    end

    // Reset gates the word so nothing loads while clear_n is low; once halted
    // only HLT is asserted.
    always_comb begin
        if (!clear_n)
            control_word = 16'h0000;
        else if (halted)
            control_word = HLT;
        else
            control_word = word;
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            step   <= 3'd0;
            halted <= 1'b0;
        end else if (!halted && step_en) begin
            if (word[15]) begin
                halted <= 1'b1;      // step freezes on the HLT T-state
            end else if (step == LAST_STEP) begin
                step <= 3'd0;
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
            end else if (step >= 3'd2 && word == 16'h0000) begin
                step <= 3'd0;        // nothing left to do in this instruction
`endif
            end else begin
                step <= step + 3'd1;
            end
        end
    end

endmodule
